// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings, the NOP
// word driven on empty queue outputs, the default reset PC and the queue entry type.
// Imported by fetch_queue and fetch_unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  localparam logic [31:0] Nop            = 32'h0000_0000;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {pc+4, instruction} pairs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         append push_data at the tail
//   pop          drop the head entry
//   clear        empty the queue (overrides push and pop)
//   push_data    entry to append
//   head         oldest entry, all zeros when empty
//   count        number of valid entries (0..2)
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  // Ignore requests that would underflow or overflow the two slots.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_data;
          end else begin
            e0_d = push_data;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data;
          else                 e1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = (count_q != 2'd0) ? e0_q : '{pc4: Nop, instr: Nop};
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues instruction-memory requests at a sequential PC,
// buffers up to two responses and presents the oldest one to the IF/ID stage.
// A redirect flushes the buffer; a request already in flight when the redirect
// arrives is completed and its data dropped.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   PCWrite                        IF/ID write enable, consumes the head entry
//   Redirect, Redirect_PC          taken branch/jump and its target
//   IM_Req, IM_Addr                registered instruction-memory request
//   IM_Ack, IM_Rdata               memory completion and instruction word
//   IF_PCplusFour, IF_Instruction  head entry (zero when empty)
//   IF_Valid                       queue non-empty
//   IF_Flush                       IF/ID flush, follows Redirect
// Optional macro FETCH_PERF_EN adds Perf_Stall_Cnt and Perf_Flush_Cnt counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Rdata,
  output logic [31:0] IF_PCplusFour,
  output logic [31:0] IF_Instruction,
  output logic        IF_Valid,
  output logic        IF_Flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] Perf_Stall_Cnt,
  output logic [31:0] Perf_Flush_Cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_q, addr_d, pc_plus4;
  logic         req_q;
  logic         pop, push;
  logic [1:0]   count;
  logic [2:0]   post_cnt;
  fetch_entry_t head;

  assign pc_plus4 = pc_q + 32'd4;
  assign IF_Valid = (count != 2'd0);
  assign pop      = IF_Valid && PCWrite && !Redirect;
  assign push     = (state_q == StBusy) && IM_Ack && !Redirect;
  // Occupancy after this cycle's pop/push; decides whether another request fits.
  assign post_cnt = {1'b0, count} - {2'b0, pop} + {2'b0, push};

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (Redirect),
    .push_data ('{pc4: pc_plus4, instr: IM_Rdata}),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (Redirect) begin
          pc_d    = Redirect_PC;
          addr_d  = Redirect_PC;
          state_d = StBusy;
        end else if (post_cnt <= 3'd1) begin
          addr_d  = pc_q;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (Redirect) begin
          pc_d = Redirect_PC;
          // Without an ack the old request stays on the bus until it completes.
          if (IM_Ack) addr_d  = Redirect_PC;
          else        state_d = StDiscard;
        end else if (IM_Ack) begin
          pc_d = pc_plus4;
          if (post_cnt <= 3'd1) addr_d  = pc_plus4;
          else                  state_d = StIdle;
        end
      end
      StDiscard: begin
        if (Redirect) pc_d = Redirect_PC;
        if (IM_Ack) begin
          state_d = StBusy;
          addr_d  = Redirect ? Redirect_PC : pc_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= (state_d != StIdle);
    end
  end

  assign IM_Req         = req_q;
  assign IM_Addr        = addr_q;
  assign IF_PCplusFour  = head.pc4;
  assign IF_Instruction = head.instr;
  assign IF_Flush       = Redirect;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (IF_Valid && !PCWrite) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Redirect)             flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Perf_Stall_Cnt = stall_cnt_q;
  assign Perf_Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 PCWrite  input  1  downstream IF/ID write enable; 1 = consume head instruction.
REQ-005 Redirect  input  1  branch/jump taken; redirect fetch.
REQ-006 Redirect_PC  input  32  redirect target address.
REQ-007 IM_Req  output  1  instruction-memory request, registered.
REQ-008 IM_Addr  output  32  request address, registered.
REQ-009 IM_Ack  input  1  memory completes request; data valid this cycle.
REQ-010 IM_Rdata  input  32  instruction word, valid with IM_Ack.
REQ-011 IF_PCplusFour  output  32  head entry PC+4.
REQ-012 IF_Instruction  output  32  head entry instruction.
REQ-013 IF_Valid  output  1  queue non-empty.
REQ-014 IF_Flush  output  1  IF/ID flush; combinationally equal to Redirect.

Function
REQ-015 Two-entry in-order queue of {pc+4, instr}; head drives IF_PCplusFour/IF_Instruction; both SHALL be 32'h0 when empty.
REQ-016 Pop when IF_Valid && PCWrite && !Redirect; push on accepted IM_Ack; simultaneous push/pop SHALL keep count unchanged.
REQ-017 FSM states IDLE (IM_Req=0), BUSY (IM_Req=1), DISCARD (IM_Req=1, response dropped).
REQ-018 IM_Req/IM_Addr SHALL stay stable from request until IM_Ack; IM_Ack only meaningful with IM_Req=1; ack in first request cycle allowed.
REQ-019 IDLE -> BUSY when post-pop count <= 1; IM_Addr <= pc.
REQ-020 BUSY & IM_Ack & !Redirect: push {pc+4, IM_Rdata}, pc <= pc+4; next BUSY with IM_Addr = new pc if post-push/pop count <= 1, else IDLE.
REQ-021 Latency: IM_Ack in cycle N -> IF_Valid=1 with that word in cycle N+1.
REQ-022 Redirect in any state: queue cleared next cycle, pc <= Redirect_PC, IF_Flush=1 same cycle.
REQ-023 Redirect in BUSY without IM_Ack -> DISCARD, IM_Addr held at old address; with IM_Ack -> data dropped, next BUSY at Redirect_PC.
REQ-024 DISCARD & IM_Ack -> BUSY at current pc; further Redirect in DISCARD updates pc only (or -> BUSY at Redirect_PC if IM_Ack same cycle).
REQ-025 Redirect outranks pop and push in the same cycle.
REQ-026 pc arithmetic modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.

Reset
REQ-027 rst_n=0 SHALL immediately force pc=RESET_PC, state IDLE, queue empty, IM_Req=0, IM_Addr=0, IF_Valid=0, IF_PCplusFour=0, IF_Instruction=0; an outstanding request is abandoned.
REQ-028 First rising edge after rst_n deasserts SHALL enter BUSY with IM_Addr=RESET_PC.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: adds outputs Perf_Stall_Cnt[31:0] (cycles IF_Valid && !PCWrite) and Perf_Flush_Cnt[31:0] (cycles Redirect), reset to 0, wrap at 2^32; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-030 Shared header fetch_defs.vh SHALL hold FSM state encodings, NOP constant 32'h0, default RESET_PC.
REQ-031 Queue SHALL be sub-module fetch_queue (2 entries, push/pop/clear, count).

Verification
REQ-032 Reset release, IM_Ack one cycle after each request, PCWrite=1 -> addresses 0,4,8,...; IF_Instruction follows IM_Rdata one cycle after ack; IF_PCplusFour 4,8,12.
REQ-033 PCWrite=0 for 5 cycles -> queue fills to 2, IM_Req=0, head unchanged; PCWrite=1 -> pops, request resumes at next sequential address.
REQ-034 Redirect to 32'h100 while request to 32'h8 pending (ack 3 cycles later) -> IF_Flush=1 that cycle, IM_Addr stays 32'h8 until ack, data dropped, next IM_Addr=32'h100.
REQ-035 Redirect coincident with IM_Ack and PCWrite -> queue empty next cycle, IF_Valid=0, next IM_Addr=Redirect_PC.
REQ-036 rst_n asserted mid-request -> all outputs 0 asynchronously; after release IM_Addr=RESET_PC; pc from 32'hFFFFFFFC wraps to 0.
REQ-037 With FETCH_PERF_EN: 3 stall cycles, 2 redirects -> Perf_Stall_Cnt=3, Perf_Flush_Cnt=2.
